// File: rtl/rr_mux_arbiter.sv
// Round-robin 4:1 grant/select with bursts of up to MAX_BURST beats; grant 1 cycle after request, one dead IDLE cycle between grants.
// Backpressure: out_ready low stalls the burst with grant, select and beat count held; dropping req[k] ends the grant.
`timescale 1ns/1ps
module rr_mux_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] in_1,
    input  logic [WIDTH-1:0] in_2,
    input  logic [WIDTH-1:0] in_3,
    input  logic [WIDTH-1:0] in_4,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             last,
    output logic [3:0]       gnt,
    output logic             s1,
    output logic             s0
);
    localparam int            CW       = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);
    localparam logic [0:0]    IDLE     = 1'b0;
    localparam logic [0:0]    BUSY     = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [3:0]    gnt_q, gnt_d;
    logic [1:0]    sel_q, sel_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic       busy;
    logic       xfer;
    logic       rel;
    logic [1:0] pick;
    logic       found;

    assign busy      = (state_q == BUSY);
    assign out_valid = busy & req[sel_q];
    assign last      = out_valid & (cnt_q == CNT_LAST);
    assign xfer      = out_valid & out_ready;
    // A dropped request ends the grant just like the final beat does.
    assign rel       = busy & (~req[sel_q] | (xfer & last));
    assign gnt       = gnt_q;
    assign s1        = sel_q[1];
    assign s0        = sel_q[0];

    always_comb begin
        pick  = ptr_q;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (!found && req[ptr_q + 2'(i)]) begin
                pick  = ptr_q + 2'(i);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        out = '0;
        if (busy) begin
            case (sel_q)
                2'd0:    out = in_1;
                2'd1:    out = in_2;
                2'd2:    out = in_3;
                default: out = in_4;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        if (!busy) begin
            if (found) begin
                state_d = BUSY;
                gnt_d   = 4'b0001 << pick;
                sel_d   = pick;
                cnt_d   = '0;
            end
        end else if (rel) begin
            state_d = IDLE;
            gnt_d   = '0;
            sel_d   = '0;
            cnt_d   = '0;
            ptr_d   = sel_q + 2'd1;
        end else if (xfer) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter: MAX_BURST=4 and MAX_BURST=1 instances share stimulus and are
// compared every cycle against a transaction-level owner/beats/pointer model.
`timescale 1ns/1ps
module tb_rr_mux_arbiter;
    logic       clk;
    logic       rst_n;
    logic       out_ready;
    logic [3:0] req;
    logic [7:0] din [4];

    logic [7:0] out0, out1;
    logic       ov0, ov1, l0, l1;
    logic [3:0] g0, g1;
    logic       s1_0, s0_0, s1_1, s0_1;

    int n_cmp;
    int n_fail;

    int m_owner [2];
    int m_beats [2];
    int m_ptr   [2];
    int m_mb    [2];

    rr_mux_arbiter #(.WIDTH(8), .MAX_BURST(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .in_1(din[0]), .in_2(din[1]), .in_3(din[2]), .in_4(din[3]),
        .out_ready(out_ready), .out(out0), .out_valid(ov0), .last(l0),
        .gnt(g0), .s1(s1_0), .s0(s0_0)
    );

    rr_mux_arbiter #(.WIDTH(8), .MAX_BURST(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .in_1(din[0]), .in_2(din[1]), .in_3(din[2]), .in_4(din[3]),
        .out_ready(out_ready), .out(out1), .out_valid(ov1), .last(l1),
        .gnt(g1), .s1(s1_1), .s0(s0_1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_owner[m] = -1;
            m_beats[m] = 0;
            m_ptr[m]   = 0;
        end
    endtask

    // Owner keeps the channel until it has moved m_mb beats or stops requesting.
    task automatic model_edge();
        for (int m = 0; m < 2; m++) begin
            int j;
            if (m_owner[m] < 0) begin
                for (int i = 0; i < 4; i++) begin
                    j = (m_ptr[m] + i) % 4;
                    if (m_owner[m] < 0 && req[j]) m_owner[m] = j;
                end
                m_beats[m] = 0;
            end else if (!req[m_owner[m]] || (out_ready && m_beats[m] == m_mb[m] - 1)) begin
                m_ptr[m]   = (m_owner[m] + 1) % 4;
                m_owner[m] = -1;
                m_beats[m] = 0;
            end else if (out_ready) begin
                m_beats[m] = m_beats[m] + 1;
            end
        end
    endtask

    function automatic logic [15:0] exp_vec(int m);
        logic [3:0] g;
        logic [1:0] s;
        logic       v, l;
        logic [7:0] o;
        if (m_owner[m] < 0) return 16'h0000;
        g = 4'b0001 << m_owner[m];
        s = 2'(m_owner[m]);
        v = req[m_owner[m]];
        l = v && (m_beats[m] == m_mb[m] - 1);
        o = din[m_owner[m]];
        return {g, s, v, l, o};
    endfunction

    function automatic logic [15:0] dvec(int m);
        return (m == 0) ? {g0, s1_0, s0_0, ov0, l0, out0} : {g1, s1_1, s0_1, ov1, l1, out1};
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
    endtask

    task automatic rand_data();
        for (int i = 0; i < 4; i++) din[i] = 8'($urandom);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req = 4'hF;
        out_ready = 1'b1;
        rand_data();
        model_reset();
        @(posedge clk);
        #4;
        for (int m = 0; m < 2; m++) begin
            n_cmp++;
            if (dvec(m) !== 16'h0000) begin
                n_fail++;
                $display("FAIL test_reset inst%0d: got %h expected %h", m, dvec(m), 16'h0000);
            end
        end
        req = 4'h0;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int xfers = 0;
        int lasts = 0;
        int last_pos = -1;
        for (int s = 0; s < 7; s++) begin
            req = (s < 5) ? 4'b0001 : 4'b0000;
            out_ready = 1'b1;
            rand_data();
            din[0] = 8'hA5;
            #3;
            for (int m = 0; m < 2; m++) begin
                n_cmp++;
                if (dvec(m) !== exp_vec(m)) begin
                    n_fail++;
                    $display("FAIL test_single inst%0d step%0d: got %h expected %h", m, s, dvec(m), exp_vec(m));
                end
            end
            if (s == 1) begin
                n_cmp++;
                if ({g0, s1_0, s0_0} !== 6'b0001_00) begin
                    n_fail++;
                    $display("FAIL single_grant: got %b expected %b", {g0, s1_0, s0_0}, 6'b0001_00);
                end
            end
            if (ov0 && out_ready) begin
                xfers++;
                if (l0) begin
                    lasts++;
                    last_pos = xfers;
                end
            end
            tick();
        end
        n_cmp++;
        if (xfers != 4 || lasts != 1 || last_pos != 4) begin
            n_fail++;
            $display("FAIL single_burst: got xfers=%0d lasts=%0d last_at=%0d expected 4 1 4", xfers, lasts, last_pos);
        end
    endtask

    task automatic test_rotate();
        logic [3:0] prev = 4'h0;
        logic [3:0] seq [$];
        logic [3:0] want [4];
        int xfers = 0;
        want = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int s = 0; s < 22; s++) begin
            req = (s < 20) ? 4'b1111 : 4'b0000;
            out_ready = 1'b1;
            rand_data();
            #3;
            for (int m = 0; m < 2; m++) begin
                n_cmp++;
                if (dvec(m) !== exp_vec(m)) begin
                    n_fail++;
                    $display("FAIL test_rotate inst%0d step%0d: got %h expected %h", m, s, dvec(m), exp_vec(m));
                end
            end
            if (g0 != 4'h0 && prev == 4'h0) seq.push_back(g0);
            if (ov0 && out_ready) xfers++;
            prev = g0;
            tick();
        end
        n_cmp++;
        if (seq.size() != 4 || xfers != 16) begin
            n_fail++;
            $display("FAIL rotate_count: got grants=%0d xfers=%0d expected 4 16", seq.size(), xfers);
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (seq[i] !== want[i]) begin
                    n_fail++;
                    $display("FAIL rotate_order[%0d]: got %b expected %b", i, seq[i], want[i]);
                end
            end
        end
    endtask

    task automatic test_stall();
        int xfers = 0;
        for (int s = 0; s < 12; s++) begin
            req = (s < 8) ? 4'b0100 : 4'b0000;
            out_ready = !(s >= 2 && s <= 4);
            rand_data();
            #3;
            for (int m = 0; m < 2; m++) begin
                n_cmp++;
                if (dvec(m) !== exp_vec(m)) begin
                    n_fail++;
                    $display("FAIL test_stall inst%0d step%0d: got %h expected %h", m, s, dvec(m), exp_vec(m));
                end
            end
            if (s >= 2 && s <= 4) begin
                n_cmp++;
                if ({ov0, g0, s1_0, s0_0} !== 7'b1_0100_10) begin
                    n_fail++;
                    $display("FAIL stall_hold step%0d: got %b expected %b", s, {ov0, g0, s1_0, s0_0}, 7'b1_0100_10);
                end
            end
            if (ov0 && out_ready && g0 == 4'b0100) xfers++;
            tick();
        end
        n_cmp++;
        if (xfers != 4) begin
            n_fail++;
            $display("FAIL stall_xfers: got %0d expected 4", xfers);
        end
    endtask

    task automatic test_drop();
        logic [3:0] prev = 4'h0;
        logic [3:0] seq [$];
        int xfers = 0;
        int lasts = 0;
        for (int s = 0; s < 11; s++) begin
            req = (s < 3) ? 4'b0110 : (s < 9) ? 4'b0100 : 4'b0000;
            out_ready = 1'b1;
            rand_data();
            #3;
            for (int m = 0; m < 2; m++) begin
                n_cmp++;
                if (dvec(m) !== exp_vec(m)) begin
                    n_fail++;
                    $display("FAIL test_drop inst%0d step%0d: got %h expected %h", m, s, dvec(m), exp_vec(m));
                end
            end
            if (g0 != 4'h0 && prev == 4'h0) seq.push_back(g0);
            if (g0 == 4'b0010 && ov0 && out_ready) begin
                xfers++;
                if (l0) lasts++;
            end
            prev = g0;
            tick();
        end
        n_cmp++;
        if (xfers != 2 || lasts != 0 || seq.size() != 2) begin
            n_fail++;
            $display("FAIL drop_burst: got xfers=%0d lasts=%0d grants=%0d expected 2 0 2", xfers, lasts, seq.size());
        end else begin
            n_cmp++;
            if (seq[0] !== 4'b0010 || seq[1] !== 4'b0100) begin
                n_fail++;
                $display("FAIL drop_order: got %b,%b expected 0010,0100", seq[0], seq[1]);
            end
        end
    endtask

    task automatic test_async_reset();
        for (int s = 0; s < 2; s++) begin
            req = 4'b0010;
            out_ready = 1'b1;
            rand_data();
            #3;
            for (int m = 0; m < 2; m++) begin
                n_cmp++;
                if (dvec(m) !== exp_vec(m)) begin
                    n_fail++;
                    $display("FAIL test_async_pre inst%0d step%0d: got %h expected %h", m, s, dvec(m), exp_vec(m));
                end
            end
            tick();
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int m = 0; m < 2; m++) begin
            n_cmp++;
            if (dvec(m) !== 16'h0000) begin
                n_fail++;
                $display("FAIL async_clear inst%0d: got %h expected %h", m, dvec(m), 16'h0000);
            end
        end
        @(posedge clk);
        #4;
        rst_n = 1'b1;
        req = 4'b1000;
        tick();
        for (int s = 0; s < 7; s++) begin
            req = (s < 5) ? 4'b1000 : 4'b0000;
            out_ready = 1'b1;
            rand_data();
            #3;
            for (int m = 0; m < 2; m++) begin
                n_cmp++;
                if (dvec(m) !== exp_vec(m)) begin
                    n_fail++;
                    $display("FAIL test_async_post inst%0d step%0d: got %h expected %h", m, s, dvec(m), exp_vec(m));
                end
            end
            if (s == 0) begin
                n_cmp++;
                if ({g0, s1_0, s0_0} !== 6'b1000_11) begin
                    n_fail++;
                    $display("FAIL async_regrant: got %b expected %b", {g0, s1_0, s0_0}, 6'b1000_11);
                end
            end
            tick();
        end
    endtask

    task automatic test_burst1();
        logic [3:0] prev = 4'h0;
        logic [3:0] seq [$];
        logic [3:0] want [4];
        int xfers = 0;
        int lasts = 0;
        want = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
        for (int s = 0; s < 10; s++) begin
            req = (s < 8) ? 4'b0101 : 4'b0000;
            out_ready = 1'b1;
            rand_data();
            #3;
            for (int m = 0; m < 2; m++) begin
                n_cmp++;
                if (dvec(m) !== exp_vec(m)) begin
                    n_fail++;
                    $display("FAIL test_burst1 inst%0d step%0d: got %h expected %h", m, s, dvec(m), exp_vec(m));
                end
            end
            if (g1 != 4'h0 && prev == 4'h0) seq.push_back(g1);
            if (ov1 && out_ready) begin
                xfers++;
                if (l1) lasts++;
            end
            prev = g1;
            tick();
        end
        n_cmp++;
        if (xfers != 4 || lasts != 4 || seq.size() != 4) begin
            n_fail++;
            $display("FAIL burst1_count: got xfers=%0d lasts=%0d grants=%0d expected 4 4 4", xfers, lasts, seq.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (seq[i] !== want[i]) begin
                    n_fail++;
                    $display("FAIL burst1_order[%0d]: got %b expected %b", i, seq[i], want[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int s = 0; s < 500; s++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 9) < 7);
            rand_data();
            if (s == 250) begin
                #1;
                rst_n = 1'b0;
                model_reset();
                #1;
                rst_n = 1'b1;
                #1;
            end else begin
                #3;
            end
            for (int m = 0; m < 2; m++) begin
                n_cmp++;
                if (dvec(m) !== exp_vec(m)) begin
                    n_fail++;
                    $display("FAIL test_random inst%0d step%0d: got %h expected %h", m, s, dvec(m), exp_vec(m));
                end
            end
            tick();
        end
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        m_mb[0] = 4;
        m_mb[1] = 1;
        rst_n = 1'b0;
        req = 4'h0;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) din[i] = 8'h00;
        model_reset();
        test_reset();
        test_single();
        test_rotate();
        test_stall();
        test_drop();
        test_async_reset();
        test_burst1();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
